// File: rtl/life_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : life_engine_if
//  Description : Bus bundle between the Game-of-Life engine and its user.
//                Groups the command inputs (step, toggle, clear, cursor) and
//                the published state (vecteur_map, busy, gen_done,
//                generation).
//                  master : drives commands, observes the grid and status
//                  slave  : the engine itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface life_engine_if #(
    parameter int LARGEUR_GRILLE = 10,
    parameter int HAUTEUR_GRILLE = 10
);
    localparam int c_N = LARGEUR_GRILLE * HAUTEUR_GRILLE;

    logic             step;
    logic             toggle;
    logic             clear;
    logic [3:0]       h_position_du_curseur;
    logic [3:0]       v_position_du_curseur;
    logic [c_N-1:0]   vecteur_map;
    logic             busy;
    logic             gen_done;
    logic [15:0]      generation;

    modport master (
        output step, toggle, clear, h_position_du_curseur, v_position_du_curseur,
        input  vecteur_map, busy, gen_done, generation
    );

    modport slave (
        input  step, toggle, clear, h_position_du_curseur, v_position_du_curseur,
        output vecteur_map, busy, gen_done, generation
    );
endinterface
`default_nettype wire

// File: rtl/life_engine.sv
`default_nettype none
// ============================================================================
//  Module      : life_engine
//  Description : Game-of-Life generation engine feeding the VGA pattern
//                generator. Holds the current grid (vecteur_map) and, on a
//                step request, evaluates one cell per clock into a shadow
//                grid, then commits the whole generation in a single cycle.
//                Supports cursor toggling in IDLE and a clear in any state.
//  Ports       : clk      - system clock
//                reset_n  - synchronous active-low reset (wins over clear)
//                bus      - life_engine_if.slave (commands, grid, status)
//  Options     : TORE_EN  - when defined, neighbours wrap around the grid
//                           edges (toroidal); otherwise outside cells are dead
//  Revision    : 1.0 - initial release
// ============================================================================
module life_engine #(
    parameter int LARGEUR_GRILLE = 10,
    parameter int HAUTEUR_GRILLE = 10,
    parameter logic [LARGEUR_GRILLE*HAUTEUR_GRILLE-1:0] CARTE_INITIALE = '0
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    life_engine_if.slave    bus
);
    localparam int         c_N      = LARGEUR_GRILLE * HAUTEUR_GRILLE;
    localparam int         c_IDX_W  = $clog2(c_N);
    localparam logic [3:0] c_X_LAST = 4'(LARGEUR_GRILLE - 1);
    localparam logic [3:0] c_Y_LAST = 4'(HAUTEUR_GRILLE - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_COMMIT  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [c_N-1:0]    r_map;
    logic [c_N-1:0]    r_shadow;
    logic [15:0]       r_gen;
    logic              r_busy;
    logic              r_done;
    logic [3:0]        r_x;
    logic [3:0]        r_y;
    logic [3:0]        w_count;
    logic              w_next;
    logic              w_last;
    logic              w_cursor_ok;
    logic [c_IDX_W-1:0] w_cell;
    logic [c_IDX_W-1:0] w_cursor_idx;

    assign bus.vecteur_map = r_map;
    assign bus.busy        = r_busy;
    assign bus.gen_done    = r_done;
    assign bus.generation  = r_gen;

    assign w_cell       = c_IDX_W'(int'(r_y) * LARGEUR_GRILLE + int'(r_x));
    assign w_last       = (r_x == c_X_LAST) && (r_y == c_Y_LAST);
    assign w_cursor_ok  = (int'(bus.h_position_du_curseur) < LARGEUR_GRILLE) &&
                          (int'(bus.v_position_du_curseur) < HAUTEUR_GRILLE);
    assign w_cursor_idx = c_IDX_W'(int'(bus.v_position_du_curseur) * LARGEUR_GRILLE +
                                   int'(bus.h_position_du_curseur));

    // Live-neighbour count of the cell under (r_x, r_y). r_map is frozen
    // during COMPUTE, so every cell sees the same generation.
    always_comb begin : p_count
        int  nx;
        int  ny;
        logic in_grid;
        w_count = '0;
        nx      = 0;
        ny      = 0;
        in_grid = 1'b0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                if (!(dx == 0 && dy == 0)) begin
                    nx = int'(r_x) + dx;
                    ny = int'(r_y) + dy;
`ifdef TORE_EN
                    if (nx < 0)                    nx = nx + LARGEUR_GRILLE;
                    else if (nx >= LARGEUR_GRILLE) nx = nx - LARGEUR_GRILLE;
                    if (ny < 0)                    ny = ny + HAUTEUR_GRILLE;
                    else if (ny >= HAUTEUR_GRILLE) ny = ny - HAUTEUR_GRILLE;
                    in_grid = 1'b1;
`else
                    in_grid = (nx >= 0) && (nx < LARGEUR_GRILLE) &&
                              (ny >= 0) && (ny < HAUTEUR_GRILLE);
`endif
                    if (in_grid) begin
                        if (r_map[c_IDX_W'(ny * LARGEUR_GRILLE + nx)]) begin
                            w_count = w_count + 4'd1;
                        end
                    end
                end
            end
        end
    end

    assign w_next = (w_count == 4'd3) | (r_map[w_cell] & (w_count == 4'd2));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (bus.step) w_state_next = S_COMPUTE;
            S_COMPUTE: if (w_last)   w_state_next = S_COMMIT;
            S_COMMIT:  w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else if (bus.clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_map    <= CARTE_INITIALE;
            r_shadow <= '0;
            r_gen    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
        end else if (bus.clear) begin
            r_map  <= '0;
            r_gen  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_x    <= '0;
            r_y    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Toggle lands this edge; COMPUTE starts next cycle and
                    // therefore already sees the toggled grid.
                    if (bus.toggle && w_cursor_ok) begin
                        r_map[w_cursor_idx] <= ~r_map[w_cursor_idx];
                    end
                    if (bus.step) begin
                        r_busy <= 1'b1;
                        r_x    <= '0;
                        r_y    <= '0;
                    end
                end
                S_COMPUTE: begin
                    r_shadow[w_cell] <= w_next;
                    if (r_x == c_X_LAST) begin
                        r_x <= '0;
                        r_y <= r_y + 4'd1;
                    end else begin
                        r_x <= r_x + 4'd1;
                    end
                end
                S_COMMIT: begin
                    r_map  <= r_shadow;
                    r_done <= 1'b1;
                    r_gen  <= r_gen + 16'd1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire
